// File: rtl/carry_propagate_adder_if.sv
// Operand/result bundle for carry_propagate_adder: the master drives operands,
// and the adder (slave) returns the registered result.
interface carry_propagate_adder_if #(
  parameter int unsigned WIDTH = 4
);
  logic             in_valid;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             cin;
  logic [WIDTH-1:0] sum;
  logic             cout;
  logic             overflow;
  logic             out_valid;

  modport master (
    output in_valid, a, b, cin,
    input  sum, cout, overflow, out_valid
  );

  modport slave (
    input  in_valid, a, b, cin,
    output sum, cout, overflow, out_valid
  );
endinterface

// File: rtl/carry_propagate_adder.sv
// Ripple-carry adder: WIDTH chained full-adder cells feeding a single register
// stage that holds sum, carry-out and signed overflow.
module cpa_full_adder (
  input  logic i_a,
  input  logic i_b,
  input  logic i_c,
  output logic o_s,
  output logic o_c
);
  logic w_g;
  logic w_p;

  assign w_g = i_a & i_b;
  assign w_p = i_a ^ i_b;
  assign o_s = w_p ^ i_c;
  assign o_c = w_g | (w_p & i_c);
endmodule

module carry_propagate_adder #(
  parameter int unsigned WIDTH = 4
) (
  input logic                  clk,
  input logic                  rst_n,
  carry_propagate_adder_if.slave bus
);
  logic [WIDTH:0]   w_c;
  logic [WIDTH-1:0] w_s;
  logic             w_ovf;

  logic [WIDTH-1:0] r_sum;
  logic             r_cout;
  logic             r_overflow;
  logic             r_out_valid;

  assign w_c[0] = bus.cin;

  for (genvar i = 0; i < WIDTH; i++) begin : g_bit
    cpa_full_adder u_fa (
      .i_a (bus.a[i]),
      .i_b (bus.b[i]),
      .i_c (w_c[i]),
      .o_s (w_s[i]),
      .o_c (w_c[i+1])
    );
  end

  // Carry into the MSB differs from carry out of it exactly on signed overflow.
  assign w_ovf = w_c[WIDTH] ^ w_c[WIDTH-1];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_sum       <= '0;
      r_cout      <= 1'b0;
      r_overflow  <= 1'b0;
      r_out_valid <= 1'b0;
    end else begin
      r_out_valid <= bus.in_valid;
      if (bus.in_valid) begin
        r_sum      <= w_s;
        r_cout     <= w_c[WIDTH];
        r_overflow <= w_ovf;
      end
    end
  end

  assign bus.sum       = r_sum;
  assign bus.cout      = r_cout;
  assign bus.overflow  = r_overflow;
  assign bus.out_valid = r_out_valid;
endmodule

// File: tb/tb_carry_propagate_adder.sv
// Scoreboard bench for carry_propagate_adder at WIDTH=4: the driver queues
// arithmetic expectations, a monitor checks every cycle's registered outputs.
module tb_carry_propagate_adder;
  typedef struct packed {
    logic [3:0] sum;
    logic       cout;
    logic       ovf;
  } exp_t;

  logic clk = 1'b0;
  logic rst_n = 1'b1;
  int   n_cmp = 0;
  int   n_bad = 0;
  exp_t q[$];
  exp_t held = '0;

  carry_propagate_adder_if #(.WIDTH(4)) bus_if ();

  carry_propagate_adder #(.WIDTH(4)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus_if)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  // Reference: plain integer arithmetic, signed range check for overflow.
  function automatic exp_t model(input int a, input int b, input int cin);
    exp_t e;
    int   u;
    int   sa;
    int   sb;
    int   s;
    u  = a + b + cin;
    sa = (a >= 8) ? a - 16 : a;
    sb = (b >= 8) ? b - 16 : b;
    s  = sa + sb + cin;
    e.sum  = 4'(u % 16);
    e.cout = (u >= 16);
    e.ovf  = (s > 7) || (s < -8);
    return e;
  endfunction

  task automatic drive(input int a, input int b, input int cin);
    @(negedge clk);
    bus_if.in_valid = 1'b1;
    bus_if.a        = 4'(a);
    bus_if.b        = 4'(b);
    bus_if.cin      = 1'(cin);
    q.push_back(model(a, b, cin));
  endtask

  task automatic idle();
    @(negedge clk);
    bus_if.in_valid = 1'b0;
    bus_if.a        = 4'($urandom);
    bus_if.b        = 4'($urandom);
    bus_if.cin      = 1'($urandom);
  endtask

  // Reset asserted mid-cycle with a live valid input that must be discarded.
  task automatic reset_pulse(input int cycles);
    @(negedge clk);
    rst_n           = 1'b0;
    bus_if.in_valid = 1'b1;
    bus_if.a        = 4'($urandom);
    bus_if.b        = 4'($urandom);
    bus_if.cin      = 1'($urandom);
    repeat (cycles) @(negedge clk);
    rst_n           = 1'b1;
    bus_if.in_valid = 1'b0;
  endtask

  // Asynchronous clear must be visible before any clock edge.
  always @(negedge rst_n) begin
    #1;
    chk("async_rst_sum", 32'(bus_if.sum), 0);
    chk("async_rst_flags", {29'd0, bus_if.cout, bus_if.overflow, bus_if.out_valid}, 0);
  end

  always begin
    @(posedge clk);
    #1;
    if (!rst_n) begin
      q.delete();
      held = '0;
      chk("rst_sum", 32'(bus_if.sum), 0);
      chk("rst_flags", {29'd0, bus_if.cout, bus_if.overflow, bus_if.out_valid}, 0);
    end else if (bus_if.out_valid) begin
      if (q.size() == 0) begin
        chk("spurious_valid", 32'(bus_if.out_valid), 0);
      end else begin
        held = q.pop_front();
        chk("result", {26'd0, bus_if.sum, bus_if.cout, bus_if.overflow}, 32'(held));
      end
    end else begin
      chk("missing_valid", 32'(q.size()), 0);
      if (q.size() != 0) q.delete();
      chk("hold", {26'd0, bus_if.sum, bus_if.cout, bus_if.overflow}, 32'(held));
    end
  end

  initial begin
    bus_if.in_valid = 1'b0;
    bus_if.a        = '0;
    bus_if.b        = '0;
    bus_if.cin      = 1'b0;
    #3;
    rst_n = 1'b0;
    repeat (4) begin
      @(negedge clk);
      bus_if.in_valid = 1'b1;
      bus_if.a        = 4'($urandom);
      bus_if.b        = 4'($urandom);
      bus_if.cin      = 1'($urandom);
    end
    @(negedge clk);
    rst_n = 1'b1;
    bus_if.in_valid = 1'b0;

    // Basic vectors, full ripple, signed overflow cases.
    drive(4'b0001, 4'b0011, 0);
    drive(4'b1010, 4'b0101, 1);
    drive(4'b1111, 4'b0001, 1);
    drive(4'b0010, 4'b0010, 0);
    drive(4'b1111, 4'b0000, 1);
    drive(4'b0111, 4'b0001, 0);
    drive(4'b1000, 4'b1000, 0);

    // Hold: one valid then three idle cycles with changing operands.
    drive(4'b0011, 4'b0100, 0);
    repeat (3) idle();

    // Exhaustive back-to-back sweep with a reset pulse halfway.
    for (int i = 0; i < 512; i++) begin
      if (i == 256) reset_pulse(2);
      drive(i[7:4], i[3:0], i[8]);
    end

    // Random traffic with random gaps.
    for (int i = 0; i < 200; i++) begin
      if ($urandom_range(0, 3) == 0) idle();
      else drive($urandom_range(0, 15), $urandom_range(0, 15), $urandom_range(0, 1));
    end

    repeat (3) idle();
    @(negedge clk);
    chk("drain", 32'(q.size()), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
